instr_fetch_unit: RTL

//  Producer side of the dual-lane instruction queue: fetches two 32-bit instructions per request from

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch producer for the dual-lane instruction queue. Each request fetches the
// words at PC and PC+4. Per-lane credits keep the queue lanes from overflowing.
module instr_fetch_unit #(
   parameter int          QUEUE_DEPTH = 16,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               stall,
   input  logic                               redirect_valid,
   input  logic [31:0]                        redirect_pc,
   output logic                               imem_req,
   output logic [31:0]                        imem_addr,
   input  logic                               imem_gnt,
   input  logic                               imem_rvalid,
   input  logic [31:0]                        imem_rdata1,
   input  logic [31:0]                        imem_rdata2,
   output logic [31:0]                        instruction_1,
   output logic [31:0]                        instruction_2,
   output logic                               instruction1_valid,
   output logic                               instruction2_valid,
   input  logic                               instr_1_pop,
   input  logic                               instr_2_pop,
   output logic [31:0]                        fetch_pc,
   output logic [1:0]                         fsm_state,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   occ1,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   occ2
);

   localparam int OW = $clog2(QUEUE_DEPTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REQ = 2'd2, WAIT = 2'd3} state_t;

   state_t      state;
   logic [31:0] pc;
   logic        drop;
   logic [31:0] redir_pc;
   logic [31:0] pc_target;
   logic        credit_ok;
   logic        go;
   logic        grant;
   logic        rsp;
   logic        release_c;

   // Handshake: a request is transferred on a cycle where imem_req && imem_gnt; imem_req and
   // imem_addr are held unchanged until then, except that a redirect retargets imem_addr.
   // Each transfer yields exactly one later imem_rvalid cycle; pushes are single-cycle strobes.
   assign redir_pc  = {redirect_pc[31:2], 2'b00};
   assign pc_target = redirect_valid ? redir_pc : pc;
   assign credit_ok = (occ1 < OW'(QUEUE_DEPTH)) && (occ2 < OW'(QUEUE_DEPTH));
   assign go        = credit_ok && !stall;
   assign grant     = (state == REQ) && imem_gnt;
   assign rsp       = (state == WAIT) && imem_rvalid;
   assign release_c = rsp && (drop || redirect_valid);
   assign fetch_pc  = pc;
   assign fsm_state = state;

   // Release from a dropped response is applied before a pop so a pop never underflows.
   function automatic logic [OW-1:0] occ_next(input logic [OW-1:0] occ, input logic inc,
                                              input logic rel, input logic pop);
      logic [OW-1:0] n;
      n = occ;
      if (rel) n = n - OW'(1);
      if (pop && (n != '0)) n = n - OW'(1);
      if (inc) n = n + OW'(1);
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= IDLE;
         pc                 <= RESET_PC;
         drop               <= 1'b0;
         imem_req           <= 1'b0;
         imem_addr          <= RESET_PC;
         instruction_1      <= '0;
         instruction_2      <= '0;
         instruction1_valid <= 1'b0;
         instruction2_valid <= 1'b0;
         occ1               <= '0;
         occ2               <= '0;
      end else begin
         occ1               <= occ_next(occ1, grant, release_c, instr_1_pop);
         occ2               <= occ_next(occ2, grant, release_c, instr_2_pop);
         instruction1_valid <= 1'b0;
         instruction2_valid <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               pc <= pc_target;
               if (go) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc_target;
               end else begin
                  state <= HOLD;
               end
            end
            REQ: begin
               if (imem_gnt) begin
                  state    <= WAIT;
                  imem_req <= 1'b0;
                  drop     <= redirect_valid;
                  pc       <= redirect_valid ? redir_pc : pc + 32'd8;
               end else if (redirect_valid) begin
                  pc        <= redir_pc;
                  imem_addr <= redir_pc;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (!drop && !redirect_valid) begin
                     instruction_1      <= imem_rdata1;
                     instruction_2      <= imem_rdata2;
                     instruction1_valid <= 1'b1;
                     instruction2_valid <= 1'b1;
                  end
                  drop <= 1'b0;
                  pc   <= pc_target;
                  if (go) begin
                     state     <= REQ;
                     imem_req  <= 1'b1;
                     imem_addr <= pc_target;
                  end else begin
                     state <= HOLD;
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
                  pc   <= redir_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
